// File: rtl/bit_composer_pkg.sv
// Shared constants for the step-grid renderer: geometry, colours, FSM states.
// Grid geometry is fixed at 16 columns x 4 rows, each cell CELL_W x CELL_H plus GAP.
package bit_composer_pkg;

  localparam int unsigned CELL_W  = 4;
  localparam int unsigned CELL_H  = 6;
  localparam int unsigned GAP     = 1;
  localparam int unsigned COLS    = 16;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned PITCH_X = CELL_W + GAP;
  localparam int unsigned PITCH_Y = CELL_H + GAP;

  localparam int unsigned COL_W = 4;
  localparam int unsigned ROW_W = 2;
  localparam int unsigned SUB_W = 3;
  localparam int unsigned PX_W  = 7;
  localparam int unsigned PY_W  = 5;

  localparam logic [SUB_W-1:0] SUB_X_GAP = SUB_W'(CELL_W);
  localparam logic [SUB_W-1:0] SUB_Y_GAP = SUB_W'(CELL_H);
  localparam logic [SUB_W-1:0] SUB_X_MAX = SUB_W'(PITCH_X - 1);
  localparam logic [SUB_W-1:0] SUB_Y_MAX = SUB_W'(PITCH_Y - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS - 1);

  localparam logic [2:0] C_BLACK    = 3'b000;
  localparam logic [2:0] C_ON       = 3'b010;
  localparam logic [2:0] C_OFF      = 3'b001;
  localparam logic [2:0] C_BEAT_ON  = 3'b100;
  localparam logic [2:0] C_BEAT_OFF = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/grid_scan_counter.sv
// Raster scan over the grid: nested subX/col and subY/row counters plus flat px/py,
// so pixel coordinates and cell position are both available without dividers.
module grid_scan_counter
  import bit_composer_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [COL_W-1:0] col_o,
  output logic [SUB_W-1:0] sub_x_o,
  output logic [ROW_W-1:0] row_o,
  output logic [SUB_W-1:0] sub_y_o,
  output logic [PX_W-1:0]  px_o,
  output logic [PY_W-1:0]  py_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_q;
  logic [SUB_W-1:0] sub_x_q;
  logic [ROW_W-1:0] row_q;
  logic [SUB_W-1:0] sub_y_q;
  logic [PX_W-1:0]  px_q;
  logic [PY_W-1:0]  py_q;
  logic             end_x_c, end_col_c, end_y_c, end_row_c;

  assign end_x_c   = (sub_x_q == SUB_X_MAX);
  assign end_col_c = (col_q == COL_MAX);
  assign end_y_c   = (sub_y_q == SUB_Y_MAX);
  assign end_row_c = (row_q == ROW_MAX);
  assign last_o    = end_x_c && end_col_c && end_y_c && end_row_c;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      col_q   <= '0;
      sub_x_q <= '0;
      row_q   <= '0;
      sub_y_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else if (clear_i) begin
      col_q   <= '0;
      sub_x_q <= '0;
      row_q   <= '0;
      sub_y_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else if (en_i) begin
      if (!end_x_c) begin
        sub_x_q <= sub_x_q + SUB_W'(1);
        px_q    <= px_q + PX_W'(1);
      end else begin
        sub_x_q <= '0;
        if (!end_col_c) begin
          col_q <= col_q + COL_W'(1);
          px_q  <= px_q + PX_W'(1);
        end else begin
          // end of a raster line: step down one pixel row
          col_q <= '0;
          px_q  <= '0;
          if (!end_y_c) begin
            sub_y_q <= sub_y_q + SUB_W'(1);
            py_q    <= py_q + PY_W'(1);
          end else begin
            sub_y_q <= '0;
            if (!end_row_c) begin
              row_q <= row_q + ROW_W'(1);
              py_q  <= py_q + PY_W'(1);
            end else begin
              row_q <= '0;
              py_q  <= '0;
            end
          end
        end
      end
    end
  end

  assign col_o   = col_q;
  assign sub_x_o = sub_x_q;
  assign row_o   = row_q;
  assign sub_y_o = sub_y_q;
  assign px_o    = px_q;
  assign py_o    = py_q;

endmodule

// File: rtl/grid_renderer.sv
// Renders the 4x16 step grid into the VGA adapter write port, one pixel per enabled cycle.
// GRID_PLAYHEAD_EN: snapshot beat, highlight its column and redraw on beat changes.
module grid_renderer
  import bit_composer_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic [7:0]  xIn,
  input  logic [6:0]  yIn,
  input  logic [15:0] qIn1,
  input  logic [15:0] qIn2,
  input  logic [15:0] qIn3,
  input  logic [15:0] qIn4,
  input  logic [3:0]  beat,
  output logic [7:0]  xOut,
  output logic [6:0]  yOut,
  output logic [2:0]  cOut,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  state_e                      state_q;
  logic [ROWS-1:0][COLS-1:0]   pat_q;
  logic [ROWS-1:0][COLS-1:0]   live_c;
  logic [7:0]                  x_org_q;
  logic [6:0]                  y_org_q;
  logic                        dirty_q;
  logic [7:0]                  x_q;
  logic [6:0]                  y_q;
  logic [2:0]                  c_q;
  logic                        plot_q, busy_q, done_q;

  logic [COL_W-1:0] col;
  logic [SUB_W-1:0] sub_x;
  logic [ROW_W-1:0] row;
  logic [SUB_W-1:0] sub_y;
  logic [PX_W-1:0]  px;
  logic [PY_W-1:0]  py;
  logic             last_c, cnt_clear_c, cnt_en_c, diff_c, beat_col_c, step_on_c;
  logic [2:0]       colour_c;

  assign live_c      = {qIn4, qIn3, qIn2, qIn1};
  assign cnt_clear_c = (state_q == SNAP);
  assign cnt_en_c    = (state_q == DRAW) && enable;

  grid_scan_counter u_scan (
    .clk     (clk),
    .resetN  (resetN),
    .clear_i (cnt_clear_c),
    .en_i    (cnt_en_c),
    .col_o   (col),
    .sub_x_o (sub_x),
    .row_o   (row),
    .sub_y_o (sub_y),
    .px_o    (px),
    .py_o    (py),
    .last_o  (last_c)
  );

`ifdef GRID_PLAYHEAD_EN
  logic [3:0] beat_q;
  assign diff_c     = (live_c != pat_q) || (beat != beat_q);
  assign beat_col_c = (col == beat_q);
`else
  logic unused_beat_c;
  assign unused_beat_c = ^beat;
  assign diff_c        = (live_c != pat_q);
  assign beat_col_c    = 1'b0;
`endif

  assign step_on_c = pat_q[row][col];

  // Pixel colour for the current scan position
  always_comb begin
    colour_c = C_BLACK;
    if ((sub_x == SUB_X_GAP) || (sub_y == SUB_Y_GAP)) begin
      colour_c = C_BLACK;
    end else if (beat_col_c) begin
      colour_c = step_on_c ? C_BEAT_ON : C_BEAT_OFF;
    end else begin
      colour_c = step_on_c ? C_ON : C_OFF;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      pat_q   <= '0;
      x_org_q <= '0;
      y_org_q <= '0;
      dirty_q <= 1'b1;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GRID_PLAYHEAD_EN
      beat_q  <= '0;
`endif
    end else begin
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (diff_c) dirty_q <= 1'b1;
          if (enable && (dirty_q || diff_c)) begin
            state_q <= SNAP;
            busy_q  <= 1'b1;
          end
        end
        SNAP: begin
          pat_q   <= live_c;
          x_org_q <= xIn;
          y_org_q <= yIn;
          dirty_q <= 1'b0;
`ifdef GRID_PLAYHEAD_EN
          beat_q  <= beat;
`endif
          state_q <= DRAW;
        end
        DRAW: begin
          if (enable) begin
            x_q    <= x_org_q + 8'(px);
            y_q    <= y_org_q + 7'(py);
            c_q    <= colour_c;
            plot_q <= 1'b1;
            if (last_c) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xOut = x_q;
  assign yOut = y_q;
  assign cOut = c_q;
  assign plot = plot_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
